// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO sweep sequencer: FSM states, the packed
// descriptor layout used by the descriptor buffer, and the output-vector layout.
package nco_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sweep_state_t;

  // Repeat count is a fixed 8-bit field.
  localparam int REPEAT_W = 8;

  // Packed descriptor, LSB first: repeat | amp | n_clk | step | n_steps | freq_init
  function automatic int off_repeat();
    return 0;
  endfunction

  function automatic int off_amp();
    return REPEAT_W;
  endfunction

  function automatic int off_n_clk(input int amp_w);
    return REPEAT_W + amp_w;
  endfunction

  function automatic int off_step(input int amp_w, input int cnt_w);
    return REPEAT_W + amp_w + cnt_w;
  endfunction

  function automatic int off_n_steps(input int amp_w, input int cnt_w, input int step_w);
    return REPEAT_W + amp_w + cnt_w + step_w;
  endfunction

  function automatic int off_freq_init(input int amp_w, input int cnt_w, input int step_w);
    return REPEAT_W + amp_w + 2 * cnt_w + step_w;
  endfunction

  function automatic int desc_width(input int freq_w, input int step_w,
                                    input int amp_w, input int cnt_w);
    return off_freq_init(amp_w, cnt_w, step_w) + freq_w;
  endfunction

  // Channel parameter vector: {freq_init, freq_mod, amp}
  function automatic int param_width(input int freq_w, input int amp_w);
    return 2 * freq_w + amp_w;
  endfunction

endpackage

// File: rtl/nco_desc_fifo.sv
// Show-ahead descriptor FIFO: the head entry is always presented on head_data,
// so the sequencer can load a descriptor in the same cycle it pops it.
module nco_desc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             ready_reg;
  logic             push_fire, pop_fire;

  // Flush overrides both push and pop; a push while full is simply not accepted.
  assign push_fire = push_valid & ready_reg & ~flush;
  assign pop_fire  = pop & ~empty & ~flush;
  assign empty     = (count_reg == '0);
  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign push_ready = ready_reg;

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else
      count_next = count_reg + CW'(push_fire) - CW'(pop_fire);
  end

  // Storage write; no reset so the array can map to RAM.
  always_ff @(posedge clk_50) begin
    if (push_fire)
      mem[wr_ptr_reg] <= push_data;
  end

  // Pointers, count and registered not-full flag.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      ready_reg <= (count_next != CW'(DEPTH));
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_fire) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

endmodule

// File: rtl/nco_sweep_sequencer.sv
// Frequency-sweep sequencer for one NCO channel: buffers sweep descriptors and
// steps frequency modulation, amplitude and the lock-in acquire strobe through them.
module nco_sweep_sequencer
  import nco_sweep_pkg::*;
#(
  parameter int FREQ_W   = 32,
  parameter int STEP_W   = 64,
  parameter int AMP_W    = 16,
  parameter int CNT_W    = 32,
  parameter int DEPTH    = 4,
  parameter int ACQ_LEAD = 1
) (
  input  logic                      clk_50,
  input  logic                      reset,
  input  logic                      start_cmd,
  input  logic                      stop_cmd,
  input  logic                      hold,
  input  logic                      clr_cmd,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [FREQ_W-1:0]         desc_freq_init,
  input  logic [CNT_W-1:0]          desc_n_steps,
  input  logic [STEP_W-1:0]         desc_step,
  input  logic [CNT_W-1:0]          desc_n_clk,
  input  logic [AMP_W-1:0]          desc_amp,
  input  logic [7:0]                desc_repeat,
  output logic [$clog2(DEPTH):0]    desc_count,
  output logic                      running,
  output logic                      paused,
  output logic                      sweep_done,
  output logic                      XY_ch_acquire,
  output logic                      NCO_ch_enable,
  output logic [2*FREQ_W+AMP_W-1:0] NCO_ch_parameters
);

  localparam int DESC_W  = desc_width(FREQ_W, STEP_W, AMP_W, CNT_W);
  localparam int O_REP   = off_repeat();
  localparam int O_AMP   = off_amp();
  localparam int O_NCLK  = off_n_clk(AMP_W);
  localparam int O_STEP  = off_step(AMP_W, CNT_W);
  localparam int O_NSTP  = off_n_steps(AMP_W, CNT_W, STEP_W);
  localparam int O_FINIT = off_freq_init(AMP_W, CNT_W, STEP_W);
  localparam logic [CNT_W-1:0] LEAD_C = CNT_W'(ACQ_LEAD);

  logic [DESC_W-1:0] push_data, head_data;
  logic              fifo_empty, load;

  assign push_data = {desc_freq_init, desc_n_steps, desc_step, desc_n_clk, desc_amp, desc_repeat};

  nco_desc_fifo #(.WIDTH(DESC_W), .DEPTH(DEPTH)) u_fifo (
    .clk_50     (clk_50),
    .reset      (reset),
    .flush      (clr_cmd),
    .push_valid (desc_valid),
    .push_ready (desc_ready),
    .push_data  (push_data),
    .pop        (load),
    .head_data  (head_data),
    .empty      (fifo_empty),
    .count      (desc_count)
  );

  // Head descriptor fields, pre-digested into effective dwell and last step index.
  logic [REPEAT_W-1:0] h_rep;
  logic [AMP_W-1:0]    h_amp;
  logic [CNT_W-1:0]    h_nclk, h_nstp, h_dwell, h_last;
  logic [STEP_W-1:0]   h_step;
  logic [FREQ_W-1:0]   h_finit;

  assign h_rep   = head_data[O_REP   +: REPEAT_W];
  assign h_amp   = head_data[O_AMP   +: AMP_W];
  assign h_nclk  = head_data[O_NCLK  +: CNT_W];
  assign h_step  = head_data[O_STEP  +: STEP_W];
  assign h_nstp  = head_data[O_NSTP  +: CNT_W];
  assign h_finit = head_data[O_FINIT +: FREQ_W];
  assign h_dwell = (h_nclk < LEAD_C) ? LEAD_C : h_nclk;
  assign h_last  = (h_nstp == '0) ? '0 : h_nstp - CNT_W'(1);

  sweep_state_t        state_reg, state_next;
  logic [FREQ_W-1:0]   finit_reg, finit_next;
  logic [AMP_W-1:0]    amp_reg, amp_next;
  logic [STEP_W-1:0]   dstep_reg, dstep_next, acc_reg, acc_next;
  logic [CNT_W-1:0]    d_reg, d_next, last_reg, last_next;
  logic [CNT_W-1:0]    dwell_reg, dwell_next, step_reg, step_next;
  logic [REPEAT_W-1:0] nrep_reg, nrep_next, rep_reg, rep_next;
  logic                en_reg, en_next, paused_reg, paused_next;
  logic                done_reg, done_next, acq_reg, acq_next;

  // Next-state: command priority stop > start > dwell end > hold.
  always_comb begin
    state_next  = state_reg;
    finit_next  = finit_reg;
    amp_next    = amp_reg;
    dstep_next  = dstep_reg;
    acc_next    = acc_reg;
    d_next      = d_reg;
    last_next   = last_reg;
    dwell_next  = dwell_reg;
    step_next   = step_reg;
    nrep_next   = nrep_reg;
    rep_next    = rep_reg;
    done_next   = 1'b0;
    load        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!stop_cmd && start_cmd && !fifo_empty)
          load = 1'b1;
      end
      default: begin
        if (stop_cmd) begin
          state_next = ST_IDLE;
        end else if (start_cmd && !fifo_empty) begin
          load = 1'b1;
        end else if (state_reg == ST_RUN) begin
          if (dwell_reg == d_reg - CNT_W'(1)) begin
            dwell_next = '0;
            if (step_reg != last_reg) begin
              step_next = step_reg + CNT_W'(1);
              acc_next  = acc_reg + dstep_reg;
            end else if (rep_reg != nrep_reg) begin
              rep_next  = rep_reg + REPEAT_W'(1);
              step_next = '0;
              acc_next  = '0;
            end else begin
              done_next = 1'b1;
              if (!fifo_empty) load = 1'b1;
              else             state_next = ST_IDLE;
            end
          end else begin
            dwell_next = dwell_reg + CNT_W'(1);
          end
          // Hold is sampled here and freezes progress from the next cycle on.
          if (hold && !load && state_next == ST_RUN)
            state_next = ST_HOLD;
        end else if (!hold) begin
          state_next = ST_RUN;
        end
      end
    endcase
    if (load) begin
      state_next = ST_RUN;
      finit_next = h_finit;
      amp_next   = h_amp;
      dstep_next = h_step;
      d_next     = h_dwell;
      last_next  = h_last;
      nrep_next  = h_rep;
      acc_next   = '0;
      dwell_next = '0;
      step_next  = '0;
      rep_next   = '0;
    end
    en_next     = (state_next != ST_IDLE);
    paused_next = (state_next == ST_HOLD);
    acq_next    = (state_next == ST_RUN) && (dwell_next == d_next - LEAD_C);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      finit_reg  <= '0;
      amp_reg    <= '0;
      dstep_reg  <= '0;
      acc_reg    <= '0;
      d_reg      <= '0;
      last_reg   <= '0;
      dwell_reg  <= '0;
      step_reg   <= '0;
      nrep_reg   <= '0;
      rep_reg    <= '0;
      en_reg     <= 1'b0;
      paused_reg <= 1'b0;
      done_reg   <= 1'b0;
      acq_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      finit_reg  <= finit_next;
      amp_reg    <= amp_next;
      dstep_reg  <= dstep_next;
      acc_reg    <= acc_next;
      d_reg      <= d_next;
      last_reg   <= last_next;
      dwell_reg  <= dwell_next;
      step_reg   <= step_next;
      nrep_reg   <= nrep_next;
      rep_reg    <= rep_next;
      en_reg     <= en_next;
      paused_reg <= paused_next;
      done_reg   <= done_next;
      acq_reg    <= acq_next;
    end
  end

  assign NCO_ch_enable     = en_reg;
  assign running           = en_reg;
  assign paused            = paused_reg;
  assign sweep_done        = done_reg;
  assign XY_ch_acquire     = acq_reg;
  assign NCO_ch_parameters = {finit_reg, acc_reg[STEP_W-1 -: FREQ_W], amp_reg};

endmodule

// File: tb/tb_nco_sweep_sequencer.sv
// Directed bench for nco_sweep_sequencer: per-cycle output traces checked
// against hand-computed vector tables, plus buffer corner-case sequences.
module tb_nco_sweep_sequencer;

  logic        clk_50 = 1'b0;
  logic        reset, start_cmd, stop_cmd, hold, clr_cmd, desc_valid;
  logic        desc_ready;
  logic [31:0] desc_freq_init, desc_n_steps, desc_n_clk;
  logic [63:0] desc_step;
  logic [15:0] desc_amp;
  logic [7:0]  desc_repeat;
  logic [2:0]  desc_count;
  logic        running, paused, sweep_done, XY_ch_acquire, NCO_ch_enable;
  logic [79:0] NCO_ch_parameters;

  nco_sweep_sequencer dut (
    .clk_50            (clk_50),
    .reset             (reset),
    .start_cmd         (start_cmd),
    .stop_cmd          (stop_cmd),
    .hold              (hold),
    .clr_cmd           (clr_cmd),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_freq_init    (desc_freq_init),
    .desc_n_steps      (desc_n_steps),
    .desc_step         (desc_step),
    .desc_n_clk        (desc_n_clk),
    .desc_amp          (desc_amp),
    .desc_repeat       (desc_repeat),
    .desc_count        (desc_count),
    .running           (running),
    .paused            (paused),
    .sweep_done        (sweep_done),
    .XY_ch_acquire     (XY_ch_acquire),
    .NCO_ch_enable     (NCO_ch_enable),
    .NCO_ch_parameters (NCO_ch_parameters)
  );

  always #10 clk_50 = ~clk_50;

  localparam int F_EN = 0, F_RUN = 1, F_FM = 2, F_FI = 3, F_ACQ = 4;
  localparam int F_DONE = 5, F_PAUSE = 6, F_CNT = 7, F_RDY = 8, F_AMP = 9;
  localparam logic [63:0] S1 = 64'h1_0000_0000;

  typedef struct {
    int          k;
    int          f;
    logic [63:0] exp;
  } vec_t;

  string       fname [10] = '{"enable", "running", "freq_mod", "freq_init", "acquire",
                              "sweep_done", "paused", "desc_count", "desc_ready", "amp"};
  logic [63:0] trace [0:63][0:9];
  vec_t        vq [$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_at(input int k, input int f, input logic [63:0] e);
    vec_t v;
    v.k = k;
    v.f = f;
    v.exp = e;
    vq.push_back(v);
  endtask

  task automatic capture(input int k);
    trace[k][F_EN]    = 64'(NCO_ch_enable);
    trace[k][F_RUN]   = 64'(running);
    trace[k][F_FM]    = 64'(NCO_ch_parameters[47:16]);
    trace[k][F_FI]    = 64'(NCO_ch_parameters[79:48]);
    trace[k][F_ACQ]   = 64'(XY_ch_acquire);
    trace[k][F_DONE]  = 64'(sweep_done);
    trace[k][F_PAUSE] = 64'(paused);
    trace[k][F_CNT]   = 64'(desc_count);
    trace[k][F_RDY]   = 64'(desc_ready);
    trace[k][F_AMP]   = 64'(NCO_ch_parameters[15:0]);
  endtask

  // Cycle 0 is the current cycle; trace[k] holds the outputs of cycle k.
  task automatic run_trace(input int n, input int start_k, input int stop_k,
                           input int h0, input int h1);
    for (int k = 0; k < n; k++) begin
      start_cmd = (k == start_k);
      stop_cmd  = (k == stop_k);
      hold      = (k >= h0) && (k <= h1);
      tick();
      capture(k + 1);
    end
    start_cmd = 1'b0;
    stop_cmd  = 1'b0;
    hold      = 1'b0;
  endtask

  task automatic check_table(input string tag);
    foreach (vq[i]) begin
      n_vec++;
      if (trace[vq[i].k][vq[i].f] !== vq[i].exp) begin
        n_err++;
        $display("FAIL %s %s@%0d: got %0d, expected %0d", tag, fname[vq[i].f],
                 vq[i].k, trace[vq[i].k][vq[i].f], vq[i].exp);
      end
    end
    vq.delete();
  endtask

  function automatic int pulses(input int f, input int k0, input int k1);
    int c = 0;
    for (int k = k0; k <= k1; k++)
      if (trace[k][f] == 64'd1) c++;
    return c;
  endfunction

  task automatic push_desc(input logic [31:0] fi, input logic [31:0] ns, input logic [63:0] st,
                           input logic [31:0] nc, input logic [15:0] am, input logic [7:0] rp);
    desc_freq_init = fi;
    desc_n_steps   = ns;
    desc_step      = st;
    desc_n_clk     = nc;
    desc_amp       = am;
    desc_repeat    = rp;
    desc_valid     = 1'b1;
    tick();
    desc_valid     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start_cmd = 1'b0; stop_cmd = 1'b0; hold = 1'b0; clr_cmd = 1'b0;
    desc_valid = 1'b0; desc_freq_init = '0; desc_n_steps = '0; desc_step = '0;
    desc_n_clk = '0; desc_amp = '0; desc_repeat = '0;
    tick(); tick();
    chk("reset enable", 64'(NCO_ch_enable), 0);
    chk("reset running", 64'(running), 0);
    chk("reset params", 64'(NCO_ch_parameters), 0);
    chk("reset count", 64'(desc_count), 0);
    chk("reset ready", 64'(desc_ready), 0);
    chk("reset acquire", 64'(XY_ch_acquire), 0);
    reset = 1'b0;
    tick();
    chk("ready after reset", 64'(desc_ready), 1);

    // Start with an empty buffer is ignored.
    expect_at(1, F_EN, 0); expect_at(2, F_RUN, 0);
    run_trace(2, 0, -1, -1, -2);
    check_table("empty_start");

    // Basic sweep: 3 steps of 5 cycles, step = 1 in freq_mod units.
    for (int k = 1; k <= 15; k++) expect_at(k, F_EN, 1);
    expect_at(1, F_FI, 1000); expect_at(1, F_AMP, 16'h1234); expect_at(1, F_CNT, 0);
    expect_at(1, F_FM, 0); expect_at(5, F_FM, 0); expect_at(6, F_FM, 1);
    expect_at(10, F_FM, 1); expect_at(11, F_FM, 2); expect_at(15, F_FM, 2);
    expect_at(4, F_ACQ, 0); expect_at(5, F_ACQ, 1); expect_at(6, F_ACQ, 0);
    expect_at(10, F_ACQ, 1); expect_at(15, F_ACQ, 1);
    expect_at(15, F_DONE, 0); expect_at(16, F_DONE, 1); expect_at(17, F_DONE, 0);
    expect_at(16, F_EN, 0); expect_at(16, F_RUN, 0);
    push_desc(1000, 3, S1, 5, 16'h1234, 0);
    chk("count after push", 64'(desc_count), 1);
    run_trace(18, 0, -1, -1, -2);
    check_table("basic");
    chk("basic acquire pulses", 64'(pulses(F_ACQ, 1, 18)), 3);
    chk("basic done pulses", 64'(pulses(F_DONE, 1, 18)), 1);

    // Two queued descriptors chain without a gap.
    expect_at(1, F_FI, 1); expect_at(3, F_FI, 1); expect_at(4, F_FI, 2);
    expect_at(4, F_EN, 1); expect_at(4, F_DONE, 1); expect_at(1, F_CNT, 1);
    expect_at(4, F_CNT, 0); expect_at(4, F_FM, 0); expect_at(5, F_FM, 0);
    expect_at(6, F_FM, 2); expect_at(7, F_FM, 2); expect_at(7, F_EN, 1);
    expect_at(8, F_EN, 0); expect_at(8, F_DONE, 1);
    push_desc(1, 1, 64'd0, 3, 0, 0);
    push_desc(2, 2, 64'h2_0000_0000, 2, 0, 0);
    chk("count two queued", 64'(desc_count), 2);
    run_trace(10, 0, -1, -1, -2);
    check_table("chain");
    chk("chain done pulses", 64'(pulses(F_DONE, 1, 10)), 2);

    // Repeat: n_steps=2, repeat=2 -> 0,s,0,s,0,s.
    expect_at(1, F_FM, 0); expect_at(2, F_FM, 0); expect_at(3, F_FM, 1);
    expect_at(4, F_FM, 1); expect_at(5, F_FM, 0); expect_at(7, F_FM, 1);
    expect_at(9, F_FM, 0); expect_at(11, F_FM, 1); expect_at(12, F_FM, 1);
    expect_at(12, F_EN, 1); expect_at(13, F_EN, 0); expect_at(13, F_DONE, 1);
    push_desc(7, 2, S1, 2, 0, 2);
    run_trace(15, 0, -1, -1, -2);
    check_table("repeat");
    chk("repeat done pulses", 64'(pulses(F_DONE, 1, 15)), 1);
    chk("repeat acquire pulses", 64'(pulses(F_ACQ, 1, 15)), 6);

    // Hold for 7 cycles mid-dwell stretches step 0 by 7 cycles.
    expect_at(2, F_PAUSE, 0); expect_at(3, F_PAUSE, 1); expect_at(9, F_PAUSE, 1);
    expect_at(10, F_PAUSE, 0); expect_at(5, F_EN, 1); expect_at(5, F_RUN, 1);
    expect_at(12, F_FM, 0); expect_at(13, F_FM, 1); expect_at(12, F_ACQ, 1);
    expect_at(17, F_ACQ, 1); expect_at(18, F_DONE, 1); expect_at(18, F_EN, 0);
    push_desc(3, 2, S1, 5, 0, 0);
    run_trace(20, 0, -1, 2, 8);
    check_table("hold");
    chk("hold no acquire while held", 64'(pulses(F_ACQ, 1, 11)), 0);
    chk("hold acquire pulses", 64'(pulses(F_ACQ, 1, 20)), 2);

    // Stop during step 1, then restart picks up the next buffered descriptor.
    expect_at(1, F_CNT, 1); expect_at(6, F_EN, 1); expect_at(6, F_FM, 1);
    expect_at(7, F_EN, 0); expect_at(7, F_RUN, 0); expect_at(7, F_CNT, 1);
    expect_at(7, F_DONE, 0);
    push_desc(11, 3, S1, 4, 0, 0);
    push_desc(22, 1, 64'd0, 2, 0, 0);
    run_trace(8, 0, 6, -1, -2);
    check_table("stop");
    chk("stop no done", 64'(pulses(F_DONE, 1, 8)), 0);
    expect_at(1, F_FI, 22); expect_at(1, F_EN, 1); expect_at(1, F_CNT, 0);
    expect_at(3, F_DONE, 1); expect_at(3, F_EN, 0);
    run_trace(4, 0, -1, -1, -2);
    check_table("restart");

    // Fill to depth, extra push dropped, flush, flush beats push.
    for (int i = 0; i < 4; i++) push_desc(32'(100 + i), 1, 64'd0, 1, 0, 0);
    chk("full count", 64'(desc_count), 4);
    chk("full ready", 64'(desc_ready), 0);
    push_desc(200, 1, 64'd0, 1, 0, 0);
    chk("extra push dropped", 64'(desc_count), 4);
    clr_cmd = 1'b1;
    tick();
    clr_cmd = 1'b0;
    chk("clr count", 64'(desc_count), 0);
    chk("clr ready", 64'(desc_ready), 1);
    clr_cmd = 1'b1;
    push_desc(201, 1, 64'd0, 1, 0, 0);
    clr_cmd = 1'b0;
    tick();
    chk("clr beats push", 64'(desc_count), 0);

    // n_clk=0 with ACQ_LEAD=1: one-cycle steps, acquire every cycle.
    expect_at(1, F_FM, 0); expect_at(2, F_FM, 1); expect_at(3, F_FM, 2);
    expect_at(1, F_ACQ, 1); expect_at(2, F_ACQ, 1); expect_at(3, F_ACQ, 1);
    expect_at(4, F_ACQ, 0); expect_at(4, F_DONE, 1); expect_at(4, F_EN, 0);
    push_desc(5, 3, S1, 0, 0, 0);
    run_trace(5, 0, -1, -1, -2);
    check_table("nclk0");

    // n_steps=0 behaves as a single step.
    expect_at(3, F_EN, 1); expect_at(3, F_FM, 0); expect_at(4, F_EN, 0);
    expect_at(4, F_DONE, 1);
    push_desc(9, 0, S1, 3, 0, 0);
    run_trace(6, 0, -1, -1, -2);
    check_table("nsteps0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
